counter_timer_arbiter: RTL and testbench
========================================

Name: counter_timer_arbiter

Overview:
- Shares one synchronous up-counter timer between two requesters.
- Each requester asks for a timed interval of len+1 clock cycles.
- The block arbitrates round-robin, loads the terminal count, sequences the counter, and returns a one-cycle done pulse to the winner.
- Sits between control logic and the counter datapath, and exposes the live count for observation.

Parameters:
- WIDTH, 3, counter and length width in bits. Count range is 0..2^WIDTH-1.

Ports:
- clk     input   1      single system clock; all state updates on the rising edge
- clrbar  input   1      asynchronous, active-low clear; resets the whole block
- req0    input   1      requester 0 interval request; level, held until done0 or abort
- len0    input   WIDTH  requester 0 terminal count; sampled only at grant
- req1    input   1      requester 1 interval request
- len1    input   WIDTH  requester 1 terminal count
- gnt0    output  1      requester 0 owns the counter
- gnt1    output  1      requester 1 owns the counter
- done0   output  1      one-cycle pulse: requester 0 interval complete
- done1   output  1      one-cycle pulse: requester 1 interval complete
- busy    output  1      high whenever state is not IDLE
- cnt_q   output  WIDTH  current counter value

Behaviour:
- Reset (clrbar=0, asynchronous, regardless of clk):
  - state=IDLE, cnt_q=0, terminal-count register tc=0.
  - gnt0=gnt1=0, done0=done1=0, busy=0.
  - last-served pointer=1, so requester 0 wins the first contention.
  - Release of clrbar is synchronous-safe: first evaluation is on the next rising edge.
- All outputs are registered; no combinational path from req/len to any output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - No req: stay in IDLE; cnt_q holds 0.
  - Exactly one req high: grant it.
  - Both req high: grant the requester not equal to last-served.
  - On the granting edge: tc<=len of the winner, cnt_q<=0, gntX<=1, last-served<=X, state<=RUN.
- RUN:
  - If cnt_q==tc: state<=DONE, doneX<=1, cnt_q holds.
  - Else: cnt_q<=cnt_q+1.
  - Interval in RUN is tc+1 cycles. tc=0 gives 1 RUN cycle; tc=2^WIDTH-1 gives 2^WIDTH cycles.
  - cnt_q never exceeds tc, so it never wraps.
- DONE (exactly one cycle):
  - doneX=1 and gntX still 1.
  - Next edge: doneX<=0, gntX<=0, cnt_q<=0, state<=IDLE.
- Cycle-level latency:
  - req sampled high at edge k → gnt high after edge k.
  - done high in the cycle after edge k+tc+1.
  - gnt low after edge k+tc+2.
  - Minimum spacing between consecutive grants: tc+3 cycles (IDLE arbitration cycle included).
- Abort:
  - If the granted req drops while in RUN, the next edge does: state<=IDLE, gntX<=0, cnt_q<=0, no done pulse.
  - last-served is still updated to the aborting requester.
  - req dropping during DONE has no effect; the done pulse completes.
- Hold rules:
  - The non-granted requester's req is ignored until IDLE; it may stay asserted and is served next.
  - len changes after grant are ignored (tc already latched).
- Invariants:
  - gnt0 and gnt1 are never both high.
  - done0 and done1 are never both high.
  - doneX implies gntX.
  - busy = (gnt0|gnt1) at all times.
- Reset mid-operation: all state is cleared immediately; no done pulse; the pointer returns to 1.

Test Plan:
- Reset then idle: clrbar=0 for 2 cycles, then 1, with no req → all outputs 0 and cnt_q=0 for 10 cycles.
- Single request: req0=1, len0=3 → gnt0 rises 1 edge later; cnt_q goes 0,1,2,3; done0 pulses one cycle while cnt_q=3; gnt0 falls the next edge.
- Contention and round-robin: req0=req1=1, len0=1, len1=2, held continuously →
  - order is gnt0 (done0 after 2 RUN cycles), IDLE, gnt1 (done1 after 3 RUN cycles), IDLE, gnt0 again;
  - the two grants never overlap.
- Boundary lengths:
  - len0=0 → exactly 1 RUN cycle, cnt_q=0, done0 on the 2nd cycle after grant.
  - len0=7 → cnt_q reaches 7 with no wrap; done0 coincides with the cycle after cnt_q=7.
- Abort: req1=1, len1=5; drop req1 when cnt_q=2 → next edge gnt1=0, cnt_q=0, done1 never asserted; a pending req0 is granted in the following IDLE cycle.
- Asynchronous reset mid-RUN: pulse clrbar low between clock edges while cnt_q=4 → outputs clear immediately without a clock edge; after release with both reqs high, gnt0 wins.

Source files
------------

// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter sharing one up-counter timer; the winner gets a done pulse after len+1 RUN cycles.
// Latency: grant one edge after req; done after edge k+tc+1. A losing req is held off until the FSM returns to IDLE.
module counter_timer_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clrbar,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] cnt_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] tc_q;
    logic             last_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done0_q;
    logic             done1_q;
    logic             busy_q;

    logic             pick1_d;
    logic             own_req_d;

    // last_q doubles as the current owner while not IDLE
    always_comb begin
        pick1_d   = req1 & (~req0 | ~last_q);
        own_req_d = last_q ? req1 : req0;
    end

    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= '0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        state_q <= RUN;
                        last_q  <= pick1_d;
                        tc_q    <= pick1_d ? len1 : len0;
                        cnt_q   <= '0;
                        gnt0_q  <= ~pick1_d;
                        gnt1_q  <= pick1_d;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    // an abort wins over a simultaneous terminal count
                    if (!own_req_d) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == tc_q) begin
                        state_q <= DONE;
                        done0_q <= ~last_q;
                        done1_q <= last_q;
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Bench for counter_timer_arbiter: expected grants queued at stimulus time, checked by a negedge monitor.
module tb_counter_timer_arbiter;

    logic       clk;
    logic       clrbar;
    logic       req0;
    logic [2:0] len0;
    logic       req1;
    logic [2:0] len1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       busy;
    logic [2:0] cnt_q;

    counter_timer_arbiter #(.WIDTH(3)) dut (
        .clk    (clk),
        .clrbar (clrbar),
        .req0   (req0),
        .len0   (len0),
        .req1   (req1),
        .len1   (len1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .busy   (busy),
        .cnt_q  (cnt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic who;
        int   tc;
        int   abort_at;
    } item_t;

    item_t sbq[$];
    int    n_chk = 0;
    int    n_bad = 0;
    bit    mon_en = 0;
    bit    active = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // sel: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 cnt_q==val
    task automatic wait_out(input string tag, input int sel, input int val, input int limit);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       ok = gnt0;
                1:       ok = gnt1;
                2:       ok = done0;
                3:       ok = done1;
                default: ok = (32'(cnt_q) == val);
            endcase
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            ok = !active && sbq.size() == 0 && !gnt0 && !gnt1;
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic push(input logic who, input int tc, input int abort_at);
        item_t it;
        it.who      = who;
        it.tc       = tc;
        it.abort_at = abort_at;
        sbq.push_back(it);
    endtask

    // Monitor: pops one expected interval per observed grant and checks its cycle-by-cycle shape
    initial begin
        logic [1:0] g;
        logic [1:0] prev_g;
        logic [1:0] exp_done;
        item_t      cur;
        int         idx;
        int         exp_cnt;
        int         explen;
        prev_g = 2'b00;
        idx    = 0;
        cur.who = 1'b0;
        cur.tc = 0;
        cur.abort_at = -1;
        forever begin
            @(negedge clk);
            g = {gnt1, gnt0};
            if (mon_en) begin
                chk("busy_eq_gnt", 32'(busy), 32'(gnt0 | gnt1));
                if (g != 2'b00 && prev_g == 2'b00) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_gnt", 1, 0);
                    end else begin
                        cur    = sbq.pop_front();
                        active = 1;
                        idx    = 0;
                        chk("gnt_who", 32'(g), cur.who ? 2 : 1);
                    end
                end else if (g != 2'b00 && g != prev_g) begin
                    chk("gnt_switch", 32'(g), 32'(prev_g));
                end
                if (active && g != 2'b00) begin
                    exp_cnt  = (idx <= cur.tc) ? idx : cur.tc;
                    exp_done = (cur.abort_at < 0 && idx == cur.tc + 1) ? (cur.who ? 2'b10 : 2'b01) : 2'b00;
                    chk("cnt", 32'(cnt_q), exp_cnt);
                    chk("done", 32'({done1, done0}), 32'(exp_done));
                    idx++;
                end else if (active && g == 2'b00) begin
                    explen = (cur.abort_at < 0) ? cur.tc + 2 : cur.abort_at + 1;
                    chk("gnt_len", idx, explen);
                    chk("cnt_after", 32'(cnt_q), 0);
                    active = 0;
                end
            end else begin
                active = 0;
            end
            prev_g = g;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrbar = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        len0   = 3'd0;
        len1   = 3'd0;

        // reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'({gnt0, gnt1, done0, done1, busy, cnt_q}), 0);
        @(negedge clk);
        clrbar = 1'b1;
        mon_en = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", 32'({gnt0, gnt1, done0, done1, busy, cnt_q}), 0);
        end

        // contention from reset: 0 first, then 1, then 0 again
        @(negedge clk);
        len0 = 3'd1;
        len1 = 3'd2;
        push(1'b0, 1, -1);
        push(1'b1, 2, -1);
        push(1'b0, 1, -1);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_out("rr_done0_a", 2, 0, 20);
        wait_out("rr_done1", 3, 0, 20);
        wait_out("rr_gnt0_b", 0, 0, 20);
        req1 = 1'b0;
        wait_out("rr_done0_b", 2, 0, 20);
        req0 = 1'b0;
        wait_idle("rr_drain");

        // single request len 3
        @(negedge clk);
        len0 = 3'd3;
        req0 = 1'b1;
        push(1'b0, 3, -1);
        @(posedge clk);
        #1;
        chk("gnt_latency", 32'({gnt1, gnt0}), 1);
        wait_out("single_done0", 2, 0, 20);
        req0 = 1'b0;
        wait_idle("single_drain");

        // boundary len 0
        @(negedge clk);
        len0 = 3'd0;
        req0 = 1'b1;
        push(1'b0, 0, -1);
        wait_out("len0_done0", 2, 0, 20);
        req0 = 1'b0;
        wait_idle("len0_drain");

        // boundary len 7; a len change after grant must be ignored
        @(negedge clk);
        len0 = 3'd7;
        req0 = 1'b1;
        push(1'b0, 7, -1);
        wait_out("len7_gnt0", 0, 0, 20);
        len0 = 3'd2;
        wait_out("len7_done0", 2, 0, 30);
        req0 = 1'b0;
        wait_idle("len7_drain");

        // abort by requester 1 at cnt 2, pending requester 0 served next
        @(negedge clk);
        len1 = 3'd5;
        req1 = 1'b1;
        push(1'b1, 5, 2);
        push(1'b0, 1, -1);
        wait_out("abort_gnt1", 1, 0, 20);
        len0 = 3'd1;
        req0 = 1'b1;
        wait_out("abort_cnt2", 4, 2, 20);
        req1 = 1'b0;
        @(negedge clk);
        chk("abort_gnt1_low", 32'({gnt1, gnt0, done1, cnt_q}), 0);
        @(negedge clk);
        chk("abort_next_gnt0", 32'({gnt1, gnt0}), 1);
        wait_out("abort_done0", 2, 0, 20);
        req0 = 1'b0;
        wait_idle("abort_drain");

        // asynchronous clear mid-RUN, then pointer back to favour requester 0
        mon_en = 0;
        @(negedge clk);
        len0 = 3'd6;
        req0 = 1'b1;
        wait_out("clr_cnt4", 4, 4, 20);
        #2;
        clrbar = 1'b0;
        #1;
        chk("async_clr", 32'({gnt0, gnt1, done0, done1, busy, cnt_q}), 0);
        req1 = 1'b1;
        @(negedge clk);
        chk("clr_hold", 32'({gnt0, gnt1, done0, done1, busy, cnt_q}), 0);
        clrbar = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_after_clr", 32'({gnt1, gnt0}), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_idle", 32'({gnt0, gnt1, done0, done1, busy, cnt_q}), 0);

        chk("sbq_empty", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
